// File: rtl/fp16_seq_pkg.sv
// Shared types and sizes for the FP16 operand sequencer.
package fp16_seq_pkg;

  localparam int SEQ_W   = 16;
  localparam int NIBBLES = SEQ_W / 4;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fp16_operand_sequencer_if.sv
// Bus between the operand sequencer, the board switches/button, the adder and the display.
interface fp16_operand_sequencer_if #(
  parameter int W = 16
);

  logic         enter_raw;
  logic [W-1:0] sw;
  logic [W-1:0] sum;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   HEX0;
  logic [3:0]   HEX1;
  logic [3:0]   HEX2;
  logic [3:0]   HEX3;
  logic         load;
  logic [1:0]   phase;

  modport master (
    input  enter_raw, sw, sum,
    output op_a, op_b, HEX0, HEX1, HEX2, HEX3, load, phase
  );

  modport slave (
    output enter_raw, sw, sum,
    input  op_a, op_b, HEX0, HEX1, HEX2, HEX3, load, phase
  );

endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: level follows raw after DEBOUNCE_CYCLES stable mismatched samples,
// press pulses once on the cycle after the level rises.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] count;
  logic          level_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      level   <= 1'b0;
      level_d <= 1'b0;
      count   <= '0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
      // Counter never wraps: it clears on a match or on the flip itself.
      if (raw == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= raw;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_operand_sequencer.sv
// Front end of the FP16 adder board: steps through operand A, operand B and sum capture,
// and feeds the 7-segment controller with the value to show plus a load strobe.
module fp16_operand_sequencer
  import fp16_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int W               = 16
) (
  input logic                    clock,
  input logic                    reset,
  fp16_operand_sequencer_if.master bus
);

  seq_state_t   state;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] sum_q;
  logic [W-1:0] shown;
  logic         load;
  logic         press;
  logic         unused_level;
  logic [3:0]   digit [NIBBLES];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .raw   (bus.enter_raw),
    .level (unused_level),
    .press (press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ENTER_A;
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      load  <= 1'b0;
    end else begin
      load <= 1'b0;
      unique case (state)
        ENTER_A: if (press) begin
          op_a  <= bus.sw;
          state <= ENTER_B;
          load  <= 1'b1;
        end
        ENTER_B: if (press) begin
          op_b  <= bus.sw;
          state <= CALC;
        end
        // One cycle so the combinational adder settles on the new op_b; presses here are dropped.
        CALC: begin
          sum_q <= bus.sum;
          state <= SHOW;
          load  <= 1'b1;
        end
        SHOW: if (press) begin
          state <= ENTER_A;
          load  <= 1'b1;
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  always_comb begin
    shown = (state == ENTER_A || state == ENTER_B) ? bus.sw : sum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      digit[i] = shown[W-1-4*i -: 4];
    end
  end

  assign bus.op_a  = op_a;
  assign bus.op_b  = op_b;
  assign bus.HEX0  = digit[0];
  assign bus.HEX1  = digit[1];
  assign bus.HEX2  = digit[2];
  assign bus.HEX3  = digit[3];
  assign bus.load  = load;
  assign bus.phase = state;

endmodule

// File: doc/fp16_operand_sequencer.md
Name: fp16_operand_sequencer

Overview:
- Front-end stage for the FP16 adder board.
- Debounces a single Enter button and steps through entry of operand A, entry of operand B, then sum capture.
- Drives both adder operands and presents the 16-bit value to show as four hex nibbles, plus a load strobe, to the 7-segment display controller directly downstream.
- Adder is combinational; this block registers its inputs and captures its output.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clock cycles the raw button must hold a new level before the debounced level changes.
- W, 16, operand/result width; fixed at 16 for FP16, must be a multiple of 4.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- enter_raw  input  1  undebounced, active-high Enter push-button.
- sw  input  W  operand switches.
- sum  input  W  combinational sum from the FP16 adder, a function of op_a/op_b.
- op_a  output  W  registered operand A to adder.
- op_b  output  W  registered operand B to adder.
- HEX0  output  4  display nibble, bits [15:12] of the shown value.
- HEX1  output  4  bits [11:8].
- HEX2  output  4  bits [7:4].
- HEX3  output  4  bits [3:0].
- load  output  1  one-cycle pulse when the shown value source changes; feeds display Load.
- phase  output  2  current state encoding, for LEDs.

Behaviour:
- Reset (synchronous): state=ENTER_A, op_a=0, op_b=0, sum_q=0, load=0, debounced level=0, debounce counter=0. Reset has priority over every other event, including mid-CALC or mid-debounce.
- Debounce:
  - Counter increments while enter_raw differs from the debounced level; clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level flips on that edge and the counter clears.
  - press = one-cycle pulse on the cycle after the debounced level rises 0->1. A release produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- States (phase encoding): ENTER_A=0, ENTER_B=1, CALC=2, SHOW=3.
  - ENTER_A: display shows sw live. On press: op_a<=sw, go to ENTER_B.
  - ENTER_B: display shows sw live. On press: op_b<=sw, go to CALC.
  - CALC: exactly one cycle, so the adder settles on the new op_b. sum_q<=sum, go to SHOW. Any press here is ignored and not queued.
  - SHOW: display shows sum_q. On press: go to ENTER_A. op_a, op_b and sum_q are retained; the next entry overwrites them.
- Display value:
  - sw in ENTER_A and ENTER_B; sum_q in CALC and SHOW.
  - sum_q is stale in CALC for one cycle; this is acceptable.
  - HEX0..HEX3 are combinational slices of the display value.
- load:
  - Registered; high for exactly one cycle on the cycle the state becomes ENTER_A (from SHOW), ENTER_B or SHOW.
  - Not asserted out of reset.
- A press that coincides with reset deassertion is lost; debounce state is cleared by reset.
- Counter width is $clog2(DEBOUNCE_CYCLES+1); no wrap, because it clears on match or flip.

Decomposition:
- Package fp16_seq_pkg holds:
  - the enum typedef for the four states, 2-bit, with the phase encoding above;
  - localparam NIBBLES = W/4.
- Sub-module button_debounce (clock, reset, raw, level, press) is instantiated once.
- The sequencer FSM, operand registers and display mux live in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset 2 cycles with enter_raw=1 -> phase=0, op_a=op_b=0, HEX0..3=sw nibbles, load=0, no press pulse.
- Debounce: enter_raw high for 3 cycles then low -> no state change. Held high for 4 cycles -> press one cycle later, phase 0->1, op_a latched, load pulses once.
- Full sequence: sw=16'h3C00, press; sw=16'h4000, press -> op_a=3C00, op_b=4000, phase passes through 2 for exactly one cycle. With the adder model returning 4200 -> phase=3, HEX0..3=4,2,0,0, load pulse on SHOW entry.
- Button held 100 cycles in ENTER_A -> exactly one press; phase advances only to 1.
- Change sw while in SHOW -> HEX outputs stay at sum_q. Press -> phase=0, HEX follows sw, op_a/op_b unchanged until the next press.
- Assert reset during CALC -> next cycle phase=0, all registers 0, no load pulse.
